shift_sequencer: RTL and testbench

Parametrised multi-step shifter for the lab datapath: holds a WIDTH-bit register, loads it on command, then runs a counted sequence of shift steps (left or right; logical, arithmetic or rotate) with a start/busy/done handshake. It generalises the earlier single-step left-by-1/right-by-3 shifter to configurable width and step sizes, adds shift modes, a step counter, an abort input and an asynchronous reset. It sits between the switch/control front end and the display/output stage.

---
 rtl/shift_sequencer_pkg.sv | 17 +
 rtl/shift_sequencer_if.sv | 27 ++
 rtl/shift_sequencer_step.sv | 54 +++++
 rtl/shift_sequencer.sv | 97 +++++++++
 tb/tb_shift_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: shift modes, direction and FSM states.
package shift_seq_pkg;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/status bundle between the control front end and the shift sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 43,
    parameter int CNT_W = 6
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] steps;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_value;
    logic             zero_flag;

    modport master (
        output load, load_value, start, dir, mode, steps, abort,
        input  busy, done, out_value, zero_flag
    );

    modport slave (
        input  load, load_value, start, dir, mode, steps, abort,
        output busy, done, out_value, zero_flag
    );
endinterface

// File: rtl/shift_sequencer_step.sv
// Purely combinational single shift step; every variant is wired bit by bit so no barrel logic is built.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH  = 43,
    parameter int STEP_L = 1,
    parameter int STEP_R = 3
) (
    input  logic [WIDTH-1:0] x,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] ror;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi >= STEP_L) begin : g_shl_src
                assign shl[gi] = x[gi-STEP_L];
            end else begin : g_shl_fill
                assign shl[gi] = 1'b0;
            end

            // Vacated top bits take zero (logical) or the sign bit (arithmetic).
            if (gi + STEP_R < WIDTH) begin : g_shr_src
                assign shr[gi] = x[gi+STEP_R];
                assign sra[gi] = x[gi+STEP_R];
            end else begin : g_shr_fill
                assign shr[gi] = 1'b0;
                assign sra[gi] = x[WIDTH-1];
            end

            assign rol[gi] = x[(gi + WIDTH - STEP_L) % WIDTH];
            assign ror[gi] = x[(gi + STEP_R) % WIDTH];
        end
    endgenerate

    // Mode 2'b11 is not decoded and therefore falls through to logical.
    always_comb begin
        y = shl;
        if (mode == MODE_ROT) begin
            y = (dir == DIR_RIGHT) ? ror : rol;
        end else if (dir == DIR_RIGHT) begin
            y = (mode == MODE_ARI) ? sra : shr;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Counted multi-step shifter: load a value, then run `steps` shift steps with start/busy/done handshake and abort.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH  = 43,
    parameter int STEP_L = 1,
    parameter int STEP_R = 3,
    parameter int CNT_W  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] step_y;

    shift_step #(
        .WIDTH  (WIDTH),
        .STEP_L (STEP_L),
        .STEP_R (STEP_R)
    ) u_step (
        .x    (value_q),
        .dir  (dir_q),
        .mode (mode_q),
        .y    (step_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= DIR_LEFT;
            mode_q  <= MODE_LOG;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        value_d = value_q;

        unique case (state_q)
            IDLE: begin
                // load wins over a start in the same cycle
                if (bus.load) begin
                    value_d = bus.load_value;
                end else if (bus.start) begin
                    dir_d   = bus.dir;
                    mode_d  = bus.mode;
                    rem_d   = bus.steps;
                    state_d = (bus.steps != '0) ? RUN : DONE;
                end
            end

            RUN: begin
                if (bus.abort) begin
                    rem_d   = '0;
                    state_d = IDLE;
                end else begin
                    value_d = step_y;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.out_value = value_q;
    assign bus.zero_flag = (value_q == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized and directed check of shift_sequencer (WIDTH=8, STEP_L=1, STEP_R=3) against a behavioural model.
module tb_shift_sequencer;

    localparam int W  = 8;
    localparam int SL = 1;
    localparam int SR = 3;
    localparam int CW = 6;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_sequencer #(
        .WIDTH  (W),
        .STEP_L (SL),
        .STEP_R (SR),
        .CNT_W  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model built from arithmetic: multiply/divide for shifts, one-bit rotations repeated.
    function automatic logic [7:0] ref_step(input logic [7:0] x, input logic d, input logic [1:0] m);
        int v, sv, r;
        v = int'(x);
        r = v;
        if (m == 2'b10) begin
            if (!d) begin
                for (int s = 0; s < SL; s++) r = ((r * 2) % 256) + (r / 128);
            end else begin
                for (int s = 0; s < SR; s++) r = (r / 2) + ((r % 2) * 128);
            end
        end else if (!d) begin
            r = (v * (1 << SL)) % 256;
        end else if (m == 2'b01) begin
            sv = (v >= 128) ? v - 256 : v;
            r  = (sv >>> SR) & 255;
        end else begin
            r = v / (1 << SR);
        end
        return 8'(r);
    endfunction

    task automatic check_out(input string tag, input logic [7:0] exp);
        chk({tag, ".value"}, 32'(bus.out_value), 32'(exp));
        chk({tag, ".zero"},  32'(bus.zero_flag), 32'(exp == 8'h00));
    endtask

    // abort_after < 0: no abort; otherwise abort once that many steps have been applied.
    task automatic run_seq(input string tag, input logic [7:0] lv, input logic d, input logic [1:0] m,
                           input int n, input int abort_after, input bit junk);
        logic [7:0] exp;
        int busy_cnt;
        bit aborted;
        busy_cnt = 0;
        aborted  = 1'b0;

        bus.load = 1'b1;
        bus.load_value = lv;
        tick();
        bus.load = 1'b0;
        exp = lv;
        check_out({tag, ".load"}, exp);

        bus.start = 1'b1;
        bus.dir   = d;
        bus.mode  = m;
        bus.steps = CW'(n);
        tick();
        bus.start = 1'b0;
        // scramble the sampled fields to show they were latched at start
        bus.dir   = ~d;
        bus.mode  = ~m;
        bus.steps = CW'($urandom);

        chk({tag, ".busy_acc"}, 32'(bus.busy), 32'd1);
        chk({tag, ".done_acc"}, 32'(bus.done), 32'(n == 0));
        check_out({tag, ".acc"}, exp);
        if (bus.busy) busy_cnt++;

        for (int i = 1; i <= n && !aborted; i++) begin
            if (abort_after == i - 1) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                check_out({tag, ".abort"}, exp);
                chk({tag, ".abort_busy"}, 32'(bus.busy), 32'd0);
                chk({tag, ".abort_done"}, 32'(bus.done), 32'd0);
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk({tag, ".post_abort_done"}, 32'(bus.done), 32'd0);
                end
                aborted = 1'b1;
            end else begin
                if (junk) begin
                    bus.load       = 1'($urandom);
                    bus.start      = 1'($urandom);
                    bus.load_value = 8'($urandom);
                end
                tick();
                bus.load  = 1'b0;
                bus.start = 1'b0;
                exp = ref_step(exp, d, m);
                check_out($sformatf("%s.step%0d", tag, i), exp);
                chk({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
                chk({tag, ".done_run"}, 32'(bus.done), 32'(i == n));
                if (bus.busy) busy_cnt++;
            end
        end

        if (!aborted) begin
            chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(n + 1));
            // load/start/abort during DONE must be ignored
            if (junk) begin
                bus.load       = 1'b1;
                bus.start      = 1'b1;
                bus.abort      = 1'b1;
                bus.load_value = ~exp;
            end
            tick();
            bus.load  = 1'b0;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, ".idle_done"}, 32'(bus.done), 32'd0);
            check_out({tag, ".idle"}, exp);
        end
        $display("seq %s: load=%02h dir=%0d mode=%0d steps=%0d abort_after=%0d -> out=%02h (exp %02h)",
                 tag, lv, d, m, n, abort_after, bus.out_value, exp);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.load_value = '0;
        bus.start = 1'b0;
        bus.dir = 1'b0;
        bus.mode = 2'b00;
        bus.steps = '0;
        bus.abort = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        chk("rst.value", 32'(bus.out_value), 32'h0);
        chk("rst.busy",  32'(bus.busy), 32'd0);
        chk("rst.done",  32'(bus.done), 32'd0);
        chk("rst.zero",  32'(bus.zero_flag), 32'd1);
        rst_n = 1'b1;
        tick();

        run_seq("left_log",   8'hB4, 1'b0, 2'b00, 3, -1, 1'b0);
        run_seq("right_ari",  8'h90, 1'b1, 2'b01, 2, -1, 1'b0);
        run_seq("right_log",  8'h90, 1'b1, 2'b00, 2, -1, 1'b0);
        run_seq("ror",        8'h81, 1'b1, 2'b10, 1, -1, 1'b0);
        run_seq("rol",        8'h81, 1'b0, 2'b10, 1, -1, 1'b0);
        run_seq("abort",      8'h01, 1'b0, 2'b00, 5,  2, 1'b1);
        run_seq("steps0",     8'h5A, 1'b1, 2'b01, 0, -1, 1'b0);
        run_seq("to_zero",    8'h80, 1'b0, 2'b00, 1, -1, 1'b0);
        run_seq("mode3",      8'hF0, 1'b1, 2'b11, 2, -1, 1'b1);
        run_seq("rot_full",   8'hC3, 1'b0, 2'b10, 8, -1, 1'b1);

        // load and start together: load wins, no sequence starts
        bus.load = 1'b1;
        bus.start = 1'b1;
        bus.load_value = 8'h3C;
        bus.steps = 6'd4;
        tick();
        bus.load = 1'b0;
        bus.start = 1'b0;
        chk("ldst.value", 32'(bus.out_value), 32'h3C);
        chk("ldst.busy",  32'(bus.busy), 32'd0);
        tick();
        chk("ldst.busy2", 32'(bus.busy), 32'd0);
        chk("ldst.done2", 32'(bus.done), 32'd0);
        $display("seq ldst: load=3c with start -> out=%02h busy=%0d", bus.out_value, bus.busy);

        // asynchronous reset in the middle of a run
        bus.load = 1'b1;
        bus.load_value = 8'hA5;
        tick();
        bus.load = 1'b0;
        bus.start = 1'b1;
        bus.dir = 1'b0;
        bus.mode = 2'b10;
        bus.steps = 6'd10;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.value", 32'(bus.out_value), 32'h0);
        chk("arst.busy",  32'(bus.busy), 32'd0);
        chk("arst.done",  32'(bus.done), 32'd0);
        chk("arst.zero",  32'(bus.zero_flag), 32'd1);
        tick();
        chk("arst.hold",  32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("seq arst: reset mid-run -> out=%02h busy=%0d", bus.out_value, bus.busy);
        tick();
        run_seq("after_rst", 8'h0F, 1'b0, 2'b01, 4, -1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] lv;
            logic d;
            logic [1:0] m;
            int n, ab;
            lv = 8'($urandom);
            d  = 1'($urandom);
            m  = 2'($urandom_range(0, 3));
            n  = int'($urandom_range(0, 12));
            ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_seq($sformatf("rnd%0d", k), lv, d, m, n, ab, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
